vertex_post_processor_scheduler: RTL and testbench

//  Shares NUM_UNITS vertex post-processor (VPP) instances between one upstream clip-space vertex stream.

---
 rtl/vpp_sched_pkg.sv | 21 ++
 rtl/vpp_sched_slot.sv | 101 ++++++++++
 rtl/vertex_post_processor_scheduler.sv | 135 +++++++++++++
 tb/tb_vertex_post_processor_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpp_sched_pkg.sv
// Shared types and helpers for the vertex post-processor scheduler.
//   slot_state_t : per-slot lifecycle state
//   IDX_W        : unit index width for the default unit count
//   next_idx     : round-robin increment with wrap at n-1
package vpp_sched_pkg;

   typedef enum logic [1:0] {
      SLOT_FREE,
      SLOT_BUSY,
      SLOT_HELD,
      SLOT_DRAIN
   } slot_state_t;

   localparam int NUM_UNITS_DEF = 3;
   localparam int IDX_W         = $clog2(NUM_UNITS_DEF);

   function automatic int next_idx(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/vpp_sched_slot.sv
// One scheduling slot bound to one VPP unit: tracks the vertex from
// dispatch to retirement, captures the unit result and drives the unit
// recovery reset.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   accept          vertex dispatched to this unit this cycle
//   retire          this slot's result consumed downstream this cycle
//   unit_done       unit done (may stay high in the unit's error state)
//   unit_invalid    unit invalid flag, sampled with done
//   unit_vertex     unit NDC result {z,y,x}
//   is_free         slot can take a new vertex
//   is_held         slot holds a result ready to retire
//   held_invalid    captured invalid flag
//   held_vertex     captured NDC result
//   unit_rst        active-high reset request to the unit
//
// state      | meaning
// SLOT_FREE  | idle, may be dispatched to
// SLOT_BUSY  | vertex in flight in the unit, waiting for done
// SLOT_HELD  | result captured, waiting for its turn to retire
// SLOT_DRAIN | retired, waiting for the unit recovery reset to finish
module vpp_sched_slot
   import vpp_sched_pkg::*;
#(
   parameter int DATAWIDTH      = 24,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   accept,
   input  logic                   retire,
   input  logic                   unit_done,
   input  logic                   unit_invalid,
   input  logic [3*DATAWIDTH-1:0] unit_vertex,
   output logic                   is_free,
   output logic                   is_held,
   output logic                   held_invalid,
   output logic [3*DATAWIDTH-1:0] held_vertex,
   output logic                   unit_rst
);

   localparam int CNT_W = $clog2(RECOVER_CYCLES + 1);
   localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES);

   slot_state_t            state_q, state_d;
   logic [3*DATAWIDTH-1:0] vertex_q, vertex_d;
   logic                   invalid_q, invalid_d;
   logic [CNT_W-1:0]       rcv_cnt_q, rcv_cnt_d;

   always_comb begin
      state_d   = state_q;
      vertex_d  = vertex_q;
      invalid_d = invalid_q;
      rcv_cnt_d = (rcv_cnt_q != '0) ? rcv_cnt_q - 1'b1 : rcv_cnt_q;
      case (state_q)
         SLOT_FREE: begin
            if (accept) state_d = SLOT_BUSY;
         end
         SLOT_BUSY: begin
            // Only the BUSY state listens to done, so a done held high by
            // a unit stuck in error is captured exactly once.
            if (unit_done) begin
               state_d   = SLOT_HELD;
               vertex_d  = unit_vertex;
               invalid_d = unit_invalid;
               if (unit_invalid) rcv_cnt_d = RECOVER_LOAD;
            end
         end
         SLOT_HELD: begin
            if (retire) state_d = (rcv_cnt_q == '0) ? SLOT_FREE : SLOT_DRAIN;
         end
         SLOT_DRAIN: begin
            if (rcv_cnt_q == '0) state_d = SLOT_FREE;
         end
         default: state_d = SLOT_FREE;
      endcase
   end

   // Reset loads the recovery counter so every unit sees its reset held
   // for RECOVER_CYCLES cycles after rst is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SLOT_FREE;
         vertex_q  <= '0;
         invalid_q <= 1'b0;
         rcv_cnt_q <= RECOVER_LOAD;
      end else begin
         state_q   <= state_d;
         vertex_q  <= vertex_d;
         invalid_q <= invalid_d;
         rcv_cnt_q <= rcv_cnt_d;
      end
   end

   assign is_free      = (state_q == SLOT_FREE);
   assign is_held      = (state_q == SLOT_HELD);
   assign held_invalid = invalid_q;
   assign held_vertex  = vertex_q;
   assign unit_rst     = rst | (rcv_cnt_q != '0);

endmodule

// File: rtl/vertex_post_processor_scheduler.sv
// Shares NUM_UNITS vertex post-processor units behind one clip-space
// vertex stream: round-robin dispatch, in-order retirement of NDC results,
// and recovery reset of units that report an invalid result.
// Optional feature macro: VPP_SCHED_STATS_EN adds accepted/invalid/stall
// counters (o_stat_accepted, o_stat_invalid, o_stat_stall).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_vertex/_dv      upstream clip-space {w,z,y,x}, valid
//   o_ready           upstream ready
//   o_unit_vertex     vertex broadcast to all units
//   o_unit_dv         one-hot start to the dispatched unit
//   o_unit_rst        active-high per-unit reset
//   i_unit_ready/_done/_invalid/_vertex   unit status and {z,y,x} results
//   o_vertex/_invalid/_dv   retired NDC result, downstream valid
//   i_ready           downstream ready
module vertex_post_processor_scheduler
   import vpp_sched_pkg::*;
#(
   parameter int DATAWIDTH      = 24,
   parameter int NUM_UNITS      = NUM_UNITS_DEF,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [4*DATAWIDTH-1:0]           i_vertex,
   input  logic                             i_vertex_dv,
   output logic                             o_ready,
   output logic [4*DATAWIDTH-1:0]           o_unit_vertex,
   output logic [NUM_UNITS-1:0]             o_unit_dv,
   output logic [NUM_UNITS-1:0]             o_unit_rst,
   input  logic [NUM_UNITS-1:0]             i_unit_ready,
   input  logic [NUM_UNITS-1:0]             i_unit_done,
   input  logic [NUM_UNITS-1:0]             i_unit_invalid,
   input  logic [3*DATAWIDTH*NUM_UNITS-1:0] i_unit_vertex,
   output logic [3*DATAWIDTH-1:0]           o_vertex,
   output logic                             o_invalid,
   output logic                             o_dv,
   input  logic                             i_ready
`ifdef VPP_SCHED_STATS_EN
   ,
   output logic [31:0]                      o_stat_accepted,
   output logic [31:0]                      o_stat_invalid,
   output logic [31:0]                      o_stat_stall
`endif
);

   localparam int PTR_W = (NUM_UNITS == NUM_UNITS_DEF) ? IDX_W : $clog2(NUM_UNITS);

   logic [PTR_W-1:0]       dispatch_ptr_q, dispatch_ptr_d;
   logic [PTR_W-1:0]       retire_ptr_q, retire_ptr_d;
   logic [NUM_UNITS-1:0]   slot_free, slot_held, slot_held_invalid;
   logic [NUM_UNITS-1:0]   slot_accept, slot_retire;
   logic [3*DATAWIDTH-1:0] slot_vertex [NUM_UNITS];
   logic                   accept, retire;

   always_comb begin
      o_ready     = slot_free[dispatch_ptr_q] & i_unit_ready[dispatch_ptr_q]
                    & ~o_unit_rst[dispatch_ptr_q];
      accept      = i_vertex_dv & o_ready;
      o_dv        = slot_held[retire_ptr_q] & ~rst;
      retire      = o_dv & i_ready;
      o_vertex    = o_dv ? slot_vertex[retire_ptr_q] : '0;
      o_invalid   = o_dv & slot_held_invalid[retire_ptr_q];
      slot_accept = '0;
      slot_retire = '0;
      slot_accept[dispatch_ptr_q] = accept;
      slot_retire[retire_ptr_q]   = retire;
      dispatch_ptr_d = accept ? PTR_W'(next_idx(int'(dispatch_ptr_q), NUM_UNITS))
                              : dispatch_ptr_q;
      retire_ptr_d   = retire ? PTR_W'(next_idx(int'(retire_ptr_q), NUM_UNITS))
                              : retire_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dispatch_ptr_q <= '0;
         retire_ptr_q   <= '0;
      end else begin
         dispatch_ptr_q <= dispatch_ptr_d;
         retire_ptr_q   <= retire_ptr_d;
      end
   end

   assign o_unit_dv     = slot_accept;
   assign o_unit_vertex = i_vertex;

   for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slot
      vpp_sched_slot #(
         .DATAWIDTH      (DATAWIDTH),
         .RECOVER_CYCLES (RECOVER_CYCLES)
      ) u_slot (
         .clk          (clk),
         .rst          (rst),
         .accept       (slot_accept[gi]),
         .retire       (slot_retire[gi]),
         .unit_done    (i_unit_done[gi]),
         .unit_invalid (i_unit_invalid[gi]),
         .unit_vertex  (i_unit_vertex[gi*3*DATAWIDTH +: 3*DATAWIDTH]),
         .is_free      (slot_free[gi]),
         .is_held      (slot_held[gi]),
         .held_invalid (slot_held_invalid[gi]),
         .held_vertex  (slot_vertex[gi]),
         .unit_rst     (o_unit_rst[gi])
      );
   end

`ifdef VPP_SCHED_STATS_EN
   logic [31:0] stat_accepted_q, stat_accepted_d;
   logic [31:0] stat_invalid_q, stat_invalid_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   always_comb begin
      stat_accepted_d = stat_accepted_q + 32'(accept);
      stat_invalid_d  = stat_invalid_q + 32'(retire & o_invalid);
      stat_stall_d    = stat_stall_q + 32'(i_vertex_dv & ~o_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_accepted_q <= '0;
         stat_invalid_q  <= '0;
         stat_stall_q    <= '0;
      end else begin
         stat_accepted_q <= stat_accepted_d;
         stat_invalid_q  <= stat_invalid_d;
         stat_stall_q    <= stat_stall_d;
      end
   end

   assign o_stat_accepted = stat_accepted_q;
   assign o_stat_invalid  = stat_invalid_q;
   assign o_stat_stall    = stat_stall_q;
`endif

endmodule

// File: tb/tb_vertex_post_processor_scheduler.sv
// Bench for vertex_post_processor_scheduler: behavioural VPP unit models,
// an arrival-order queue of expected results, directed scenarios and a
// randomized run.
module tb_vertex_post_processor_scheduler;

   localparam int DW = 24;
   localparam int NU = 3;
   localparam int RC = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [4*DW-1:0]      i_vertex;
   logic                 i_vertex_dv;
   logic                 o_ready;
   logic [4*DW-1:0]      o_unit_vertex;
   logic [NU-1:0]        o_unit_dv;
   logic [NU-1:0]        o_unit_rst;
   logic [NU-1:0]        i_unit_ready;
   logic [NU-1:0]        i_unit_done;
   logic [NU-1:0]        i_unit_invalid;
   logic [3*DW*NU-1:0]   i_unit_vertex;
   logic [3*DW-1:0]      o_vertex;
   logic                 o_invalid;
   logic                 o_dv;
   logic                 i_ready;
`ifdef VPP_SCHED_STATS_EN
   logic [31:0]          o_stat_accepted, o_stat_invalid, o_stat_stall;
`endif

   vertex_post_processor_scheduler #(
      .DATAWIDTH(DW), .NUM_UNITS(NU), .RECOVER_CYCLES(RC)
   ) dut (
      .clk(clk), .rst(rst), .i_vertex(i_vertex), .i_vertex_dv(i_vertex_dv),
      .o_ready(o_ready), .o_unit_vertex(o_unit_vertex), .o_unit_dv(o_unit_dv),
      .o_unit_rst(o_unit_rst), .i_unit_ready(i_unit_ready), .i_unit_done(i_unit_done),
      .i_unit_invalid(i_unit_invalid), .i_unit_vertex(i_unit_vertex),
      .o_vertex(o_vertex), .o_invalid(o_invalid), .o_dv(o_dv), .i_ready(i_ready)
`ifdef VPP_SCHED_STATS_EN
      , .o_stat_accepted(o_stat_accepted), .o_stat_invalid(o_stat_invalid),
      .o_stat_stall(o_stat_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3*DW-1:0] res;
      bit              inv;
   } exp_t;

   exp_t            q[$];
   int              ret_cycs[$];
   int              n_checks = 0, n_pass = 0;
   int              cyc = 0, exp_dp = 0, n_ret = 0, n_inv_ret = 0, dv_seen = 0;
   int              st_acc = 0, st_inv = 0, st_stall = 0;
   int              nxt_lat = 2;
   bit              nxt_err = 1'b0;

   bit              u_busy [NU];
   bit              u_done [NU];
   bit              u_err  [NU];
   int              u_left [NU];
   logic [3*DW-1:0] u_res  [NU];
   int              rst_hi [NU];

   bit              s_xfer, s_dv, s_ready, s_invalid;
   logic [NU-1:0]   s_unit_rst, s_unit_dv;
   logic [3*DW-1:0] s_vertex;

   // Unit transfer function: any fixed mapping works, the scheduler only
   // has to deliver the right unit's result in the right order.
   function automatic logic [3*DW-1:0] res_of(input logic [4*DW-1:0] v);
      return {v[71:48] + v[95:72], v[47:24] - 24'd1, v[23:0] ^ 24'h5A5A5A};
   endfunction

   task automatic check_eq(input string tag, input logic [127:0] obs,
                           input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic drive_units();
      for (int u = 0; u < NU; u++) begin
         i_unit_done[u]              = u_done[u];
         i_unit_invalid[u]           = u_done[u] & u_err[u];
         i_unit_ready[u]             = !u_busy[u] && !u_done[u];
         i_unit_vertex[u*3*DW +: 3*DW] = u_res[u];
      end
   endtask

   task automatic tick();
      bit            xfer;
      int            d;
      logic [NU-1:0] oh;
      @(negedge clk);
      cyc++;
      xfer       = i_vertex_dv && o_ready && !rst;
      s_xfer     = xfer;
      s_dv       = o_dv;
      s_ready    = o_ready;
      s_invalid  = o_invalid;
      s_unit_rst = o_unit_rst;
      s_unit_dv  = o_unit_dv;
      s_vertex   = o_vertex;
      if (o_dv) dv_seen++;
      d = exp_dp;
      if (rst) begin
         q.delete();
         exp_dp = 0;
         st_acc = 0; st_inv = 0; st_stall = 0;
      end else begin
         oh = '0;
         if (xfer) oh[d] = 1'b1;
         check_eq("unit_dv", o_unit_dv, oh);
         if (xfer) begin
            check_eq("unit_ready_at_accept", i_unit_ready[d], 1'b1);
            q.push_back('{res_of(i_vertex), nxt_err});
            exp_dp = (d + 1) % NU;
            st_acc++;
         end
         if (i_vertex_dv && !o_ready) st_stall++;
         if (o_dv) begin
            if (q.size() == 0) check_eq("dv_without_pending", o_dv, 1'b0);
            else begin
               check_eq("retire_invalid", o_invalid, q[0].inv);
               if (!q[0].inv) check_eq("retire_vertex", o_vertex, q[0].res);
               if (i_ready) begin
                  if (q[0].inv) begin st_inv++; n_inv_ret++; end
                  void'(q.pop_front());
                  n_ret++;
                  ret_cycs.push_back(cyc);
               end
            end
         end
      end
      for (int u = 0; u < NU; u++) begin
         if (o_unit_rst[u]) begin
            u_busy[u] = 1'b0; u_done[u] = 1'b0; u_err[u] = 1'b0;
            rst_hi[u]++;
         end else begin
            if (u_done[u] && !u_err[u]) u_done[u] = 1'b0;
            if (u_busy[u]) begin
               if (u_left[u] == 1) begin u_busy[u] = 1'b0; u_done[u] = 1'b1; end
               else u_left[u]--;
            end
         end
      end
      if (xfer) begin
         u_busy[d] = 1'b1;
         u_left[d] = nxt_lat - 1;
         u_err[d]  = nxt_err;
         u_res[d]  = res_of(i_vertex);
      end
      @(posedge clk);
      #1;
      drive_units();
   endtask

   task automatic do_reset();
      rst = 1'b1; i_vertex_dv = 1'b0;
      tick();
      rst = 1'b0;
      repeat (RC + 1) tick();
      for (int u = 0; u < NU; u++) rst_hi[u] = 0;
   endtask

   task automatic send(input logic [4*DW-1:0] v, input int lat, input bit err);
      i_vertex = v; i_vertex_dv = 1'b1; nxt_lat = lat; nxt_err = err;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (s_xfer) break;
      end
      check_eq("send_accepted", s_xfer, 1'b1);
      i_vertex_dv = 1'b0;
   endtask

   task automatic wait_retires(input int n);
      int target;
      target = n_ret + n;
      for (int k = 0; k < 80 && n_ret < target; k++) tick();
      check_eq("retire_count", n_ret, target);
   endtask

   initial begin
      int t0, n0, d0;
      logic [4*DW-1:0] v;
      rst = 1'b1; i_vertex = '0; i_vertex_dv = 1'b0; i_ready = 1'b1;
      for (int u = 0; u < NU; u++) begin
         u_busy[u] = 0; u_done[u] = 0; u_err[u] = 0; u_left[u] = 0;
         u_res[u] = '0; rst_hi[u] = 0;
      end
      drive_units();

      // reset state and recovery window
      tick();
      check_eq("rst_unit_rst", s_unit_rst, 3'b111);
      check_eq("rst_ready", s_ready, 1'b0);
      check_eq("rst_dv", s_dv, 1'b0);
      check_eq("rst_invalid", s_invalid, 1'b0);
      check_eq("rst_vertex", s_vertex, 72'h0);
      rst = 1'b0;
      for (int k = 0; k < RC; k++) begin
         tick();
         check_eq("recover_unit_rst", s_unit_rst, 3'b111);
         check_eq("recover_ready", s_ready, 1'b0);
      end
      tick();
      check_eq("post_recover_unit_rst", s_unit_rst, 3'b000);
      check_eq("post_recover_ready", s_ready, 1'b1);

      // single vertex, Q13 (1.0, 2.0, 0.5, 4.0), 20-cycle unit latency
      v = {24'd32768, 24'd4096, 24'd16384, 24'd8192};
      send(v, 20, 1'b0);
      check_eq("single_to_unit0", s_unit_dv, 3'b001);
      t0 = cyc;
      for (int k = 0; k < 40 && !s_dv; k++) tick();
      check_eq("single_done_to_dv", cyc - t0, 21);
      check_eq("single_vertex", s_vertex, res_of(v));
      check_eq("single_invalid", s_invalid, 1'b0);
      send(96'h000010_000020_000030_000040, 2, 1'b0);
      check_eq("second_to_unit1", s_unit_dv, 3'b010);
      t0 = cyc;
      for (int k = 0; k < 40 && !s_dv; k++) tick();
      check_eq("retire_ptr_advanced", cyc - t0, 3);

      // out of order completion, in-order retirement
      do_reset();
      ret_cycs.delete();
      send(96'h111111_222222_333333_444444, 20, 1'b0);
      t0 = cyc;
      send(96'h555555_666666_777777_888888, 20, 1'b0);
      send(96'h999999_AAAAAA_BBBBBB_CCCCCC, 3, 1'b0);
      check_eq("ooo_back_to_back", cyc - t0, 2);
      wait_retires(3);
      check_eq("ooo_ret0", ret_cycs[0] - t0, 21);
      check_eq("ooo_ret1", ret_cycs[1] - t0, 22);
      check_eq("ooo_ret2", ret_cycs[2] - t0, 23);

      // invalid result with done/invalid held by the unit
      do_reset();
      n0 = n_ret; d0 = n_inv_ret;
      send(96'h000001_000002_000003_000004, 4, 1'b0);
      send(96'h000005_000006_000007_000008, 6, 1'b1);
      wait_retires(2);
      repeat (4) tick();
      check_eq("inv_retires", n_ret - n0, 2);
      check_eq("inv_captured_once", n_inv_ret - d0, 1);
      check_eq("inv_unit1_rst_cycles", rst_hi[1], RC);
      check_eq("inv_unit0_no_rst", rst_hi[0], 0);
      send(96'h00000A_00000B_00000C_00000D, 2, 1'b0);
      send(96'h00000E_00000F_000010_000011, 2, 1'b0);
      send(96'h000012_000013_000014_000015, 2, 1'b0);
      check_eq("inv_slot1_reused", s_unit_dv, 3'b010);
      wait_retires(3);

      // backpressure with all three slots held
      do_reset();
      i_ready = 1'b0;
      v = 96'h0ABCDE_123456_654321_0FEDCB;
      send(v, 3, 1'b0);
      send(96'h001111_002222_003333_004444, 3, 1'b0);
      send(96'h005555_006666_007777_008888, 3, 1'b0);
      repeat (4) tick();
      n0 = n_ret;
      i_vertex = 96'hDEAD00_BEEF00_CAFE00_F00D00; i_vertex_dv = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check_eq("bp_ready_low", s_ready, 1'b0);
         check_eq("bp_dv_held", s_dv, 1'b1);
         check_eq("bp_vertex_stable", s_vertex, res_of(v));
      end
      i_vertex_dv = 1'b0; i_ready = 1'b1;
      repeat (3) tick();
      check_eq("bp_three_retires", n_ret - n0, 3);

      // reset with two vertices in flight
      do_reset();
      send(96'h100000_200000_300000_400000, 10, 1'b0);
      send(96'h500000_600000_700000_800000, 10, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check_eq("midrst_unit_rst", s_unit_rst, 3'b111);
      rst = 1'b0;
      d0 = dv_seen;
      tick();
      check_eq("midrst_unit_rst_after", s_unit_rst, 3'b111);
      repeat (25) tick();
      check_eq("midrst_no_dv", dv_seen - d0, 0);
      send(96'h000100_000200_000300_000400, 2, 1'b0);
      check_eq("midrst_next_unit0", s_unit_dv, 3'b001);
      wait_retires(1);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         i_vertex_dv = ($urandom_range(0, 9) < 7);
         i_vertex    = {$urandom, $urandom, $urandom};
         i_ready     = ($urandom_range(0, 3) != 0);
         nxt_lat     = $urandom_range(2, 9);
         nxt_err     = ($urandom_range(0, 7) == 0);
         tick();
      end
      i_vertex_dv = 1'b0; i_ready = 1'b1;
      repeat (60) tick();
      check_eq("drain_empty", q.size(), 0);

`ifdef VPP_SCHED_STATS_EN
      check_eq("stat_accepted", o_stat_accepted, st_acc);
      check_eq("stat_invalid", o_stat_invalid, st_inv);
      check_eq("stat_stall", o_stat_stall, st_stall);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
